// File: rtl/mem_pkg.sv
// Shared sizing constants and word types for the
// small register-array memory and its bench.
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 8;
    localparam int MEM_ADDR_WIDTH = 2;
    localparam int MEM_DEPTH      = 1 << MEM_ADDR_WIDTH;

    typedef logic [MEM_DATA_WIDTH-1:0] word_t;
    typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/modport_mem_if.sv
// Access bus of the memory: one address, write and
// read strobes, write data and registered read data.
interface modport_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output addr,
        output wr_en,
        output rd_en,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  rd_en,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/modport_mem.sv
// Register-array memory with one write port and one
// registered read port; reads return pre-write data.
module modport_mem
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    modport_mem_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Read samples mem_q, so a same-address write
    // lands after the old word has been captured.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (bus.wr_en) begin
            mem_d[bus.addr] = bus.wdata;
        end
        if (bus.rd_en) begin
            rdata_d = mem_q[bus.addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_modport_mem.sv
// Directed and randomised checks of modport_mem
// against hand-computed values and a small model.
module tb_modport_mem;
    import mem_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    modport_mem_if #(
        .DATA_WIDTH(MEM_DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) bus ();

    modport_mem #(
        .DATA_WIDTH(MEM_DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered 1 unit after an edge: drive, sample rdata
    // 1 unit before the next edge (result of the previous
    // step), then cross that edge.
    task automatic step(input logic rst, input logic wr,
                        input logic rd, input addr_t a,
                        input word_t d, output word_t obs);
        reset     = rst;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.addr  = a;
        bus.wdata = d;
        #8;
        obs = bus.rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        word_t obs;
        step(1, 0, 0, 0, 0, obs);
        step(1, 0, 0, 0, 0, obs);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, addr_t'(i), 0, obs);
            checks++;
            if (obs !== 8'h00) begin
                failures++;
                $display("FAIL reset_rd%0d got=%h exp=00", i, obs);
            end
        end
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd3 got=%h exp=00", obs);
        end
    endtask

    task automatic test_write_read();
        word_t obs;
        word_t exp_v [4];
        exp_v[0] = 8'h11;
        exp_v[1] = 8'h22;
        exp_v[2] = 8'h33;
        exp_v[3] = 8'h44;
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, addr_t'(i), exp_v[i], obs);
        step(0, 0, 1, 0, 0, obs);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(0, 0, 1, addr_t'(i + 1), 0, obs);
            else       step(0, 0, 0, 0, 0, obs);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_rd%0d got=%h exp=%h",
                         i, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_rbw();
        word_t obs;
        step(0, 1, 1, 2, 8'hAB, obs);
        step(0, 0, 1, 2, 0, obs);
        checks++;
        if (obs !== 8'h33) begin
            failures++;
            $display("FAIL rbw_old got=%h exp=33", obs);
        end
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'hAB) begin
            failures++;
            $display("FAIL rbw_new got=%h exp=ab", obs);
        end
    endtask

    task automatic test_idle_hold();
        word_t obs;
        step(0, 1, 0, 1, 8'h5A, obs);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 'x, 'x, obs);
            checks++;
            if (obs !== 8'hAB) begin
                failures++;
                $display("FAIL idle_hold%0d got=%h exp=ab", i, obs);
            end
        end
        step(0, 0, 1, 1, 0, obs);
        step(0, 0, 1, 3, 0, obs);
        checks++;
        if (obs !== 8'h5A) begin
            failures++;
            $display("FAIL idle_rd1 got=%h exp=5a", obs);
        end
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'h44) begin
            failures++;
            $display("FAIL idle_rd3 got=%h exp=44", obs);
        end
    endtask

    task automatic test_diff_addr();
        word_t obs;
        step(0, 1, 1, 0, 8'hC3, obs);
        bus.addr = 1;
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'h11) begin
            failures++;
            $display("FAIL diff_rd0old got=%h exp=11", obs);
        end
        step(0, 0, 1, 0, 0, obs);
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'hC3) begin
            failures++;
            $display("FAIL diff_wr0 got=%h exp=c3", obs);
        end
    endtask

    task automatic test_same_addr_writes();
        word_t obs;
        step(0, 1, 0, 3, 8'h01, obs);
        step(0, 1, 0, 3, 8'h02, obs);
        step(0, 0, 1, 3, 0, obs);
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'h02) begin
            failures++;
            $display("FAIL last_write got=%h exp=02", obs);
        end
    endtask

    task automatic test_reset_mid();
        word_t obs;
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, addr_t'(i), 8'hFF, obs);
        step(0, 0, 1, 2, 0, obs);
        step(1, 1, 1, 0, 8'h77, obs);
        checks++;
        if (obs !== 8'hFF) begin
            failures++;
            $display("FAIL fill_ff got=%h exp=ff", obs);
        end
        step(0, 1, 1, 1, 8'h99, obs);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rst_rdata got=%h exp=00", obs);
        end
        step(0, 0, 1, 1, 0, obs);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rst_mem0 got=%h exp=00", obs);
        end
        step(0, 0, 1, 2, 0, obs);
        checks++;
        if (obs !== 8'h99) begin
            failures++;
            $display("FAIL post_rst_wr got=%h exp=99", obs);
        end
        step(0, 0, 1, 3, 0, obs);
        step(0, 0, 0, 0, 0, obs);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL rst_mem3 got=%h exp=00", obs);
        end
    endtask

    task automatic test_random();
        word_t obs;
        word_t model [4];
        word_t exp_rd;
        logic  wr;
        logic  rd;
        addr_t a;
        word_t d;
        step(1, 0, 0, 0, 0, obs);
        for (int i = 0; i < 4; i++) model[i] = '0;
        exp_rd = '0;
        for (int n = 0; n < 1000; n++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            a  = addr_t'($urandom_range(0, 3));
            d  = word_t'($urandom_range(0, 255));
            step(0, wr, rd, a, d, obs);
            checks++;
            if (obs !== exp_rd) begin
                failures++;
                $display("FAIL rand%0d got=%h exp=%h", n, obs, exp_rd);
            end
            if (rd) exp_rd = model[a];
            if (wr) model[a] = d;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_rbw();
        test_idle_hold();
        test_diff_addr();
        test_same_addr_writes();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modport_mem.md
MODPORT_MEM -- requirements
Module: modport_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each memory word and of wdata/rdata.
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the address width; depth = 2**ADDR_WIDTH (4 words by default).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port addr, input, ADDR_WIDTH, SHALL give the word address for read and write.
REQ-006 Port wr_en, input, 1, SHALL request a write of wdata to addr.
REQ-007 Port rd_en, input, 1, SHALL request a read of addr.
REQ-008 Port wdata, input, DATA_WIDTH, SHALL carry the write data.
REQ-009 Port rdata, output, DATA_WIDTH, SHALL carry registered read data.

Function
REQ-010 Storage SHALL be DEPTH words of DATA_WIDTH bits, all addressed through addr; no out-of-range address exists.
REQ-011 Write: a rising edge with reset=0 and wr_en=1 SHALL store wdata into mem[addr]; the store is visible to reads issued from the next cycle onward.
REQ-012 Read: a rising edge with reset=0 and rd_en=1 SHALL load mem[addr] into rdata; rdata is valid right after that edge (1-cycle latency).
REQ-013 rdata SHALL hold its last value on every edge where rd_en=0; idle cycles SHALL NOT alter memory or rdata.
REQ-014 Simultaneous wr_en=1 and rd_en=1 to the same address SHALL write wdata and return the OLD contents on rdata (read-before-write).
REQ-015 Simultaneous wr_en=1 and rd_en=1 to different addresses SHALL perform both operations independently in the same cycle.
REQ-016 Back-to-back writes/reads on consecutive cycles SHALL be accepted every cycle; no handshake or stall exists.
REQ-017 Consecutive writes to the same address SHALL leave the last written value.
REQ-018 X/Z on addr or wdata while wr_en=0 and rd_en=0 SHALL NOT affect state.

Reset
REQ-019 On a rising edge with reset=1, every memory word SHALL become 0 and rdata SHALL become 0.
REQ-020 While reset=1, wr_en and rd_en SHALL be ignored; reset takes priority over any simultaneous access.
REQ-021 Reset asserted mid-operation SHALL discard the in-progress access; the first access after reset deasserts SHALL be honoured on the first edge with reset=0.
REQ-022 No asynchronous path from reset to any output SHALL exist.

Structure
REQ-023 A shared package mem_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, the derived DEPTH constant and a data-word typedef, used by RTL and bench.
REQ-024 The block SHALL be a single module with no sub-modules; storage is an internal register array with one registered read port.
REQ-025 Bench drive SHALL change inputs 1 time unit after the rising edge and sample rdata 1 time unit before the rising edge; the design SHALL meet this with registered outputs only.

Verification
REQ-026 Reset 2 cycles, then rd_en at addr 0..3 -> rdata = 0x00 each, one cycle after each read.
REQ-027 Write 0x11,0x22,0x33,0x44 to addr 0..3, then read 0..3 back-to-back -> rdata 0x11,0x22,0x33,0x44 on consecutive cycles.
REQ-028 mem[2]=0x33, same cycle wr_en=1 rd_en=1 addr=2 wdata=0xAB -> rdata=0x33; next read addr 2 -> 0xAB.
REQ-029 Write 0x5A to addr 1, then 3 idle cycles -> rdata unchanged from prior read; read addr 1 -> 0x5A.
REQ-030 Fill memory with 0xFF, assert reset 1 cycle concurrent with wr_en addr 0 wdata 0x77 -> all reads return 0x00, rdata=0x00 right after reset.
REQ-031 Random wr/rd mix (1000 cycles) against a 4-entry scoreboard model -> zero mismatches.
